pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 32: width of each performance counter.
REQ-002 SHALL have parameter MD_TIMEOUT, default 64: maximum MD_WAIT cycles before abort (legal range 2..255).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port load_use_hzd  input  1  load-use stall request from the hazard unit, ID stage.
REQ-006 SHALL have port ex_branch_taken  input  1  taken branch or jump resolved in EX.
REQ-007 SHALL have port md_req  input  1  EX holds a multi-cycle mul/div instruction.
REQ-008 SHALL have port md_ready  input  1  mul/div unit result valid.
REQ-009 SHALL have port md_start  output  1  one-cycle start pulse to the mul/div unit.
REQ-010 SHALL have port md_abort  output  1  one-cycle abort pulse to the mul/div unit on timeout.
REQ-011 SHALL have ports pc_en, ifid_en, idex_en  output  1 each  register-load enables for PC, IF/ID and ID/EX.
REQ-012 SHALL have ports ifid_flush, idex_flush, exmem_flush  output  1 each  bubble insertion into the named register.
REQ-013 SHALL have port md_err  output  1  sticky timeout flag.
REQ-014 SHALL have ports stall_cnt, flush_cnt  output  CNT_W each  performance counters.

Function
REQ-015 SHALL implement the states RUN and MD_WAIT; outputs SHALL be Mealy: a function of state and the current inputs.
REQ-016 In RUN with no request, outputs SHALL be: all enables 1, all flushes 0, and md_start/md_abort 0.
REQ-017 Request priority in RUN SHALL be md_req > ex_branch_taken > load_use_hzd; a lower-priority request that coincides with a higher one SHALL be ignored that cycle.
REQ-018 On ex_branch_taken in RUN: ifid_flush=1 and idex_flush=1 in the same cycle, enables stay 1, state stays RUN; the flush lasts one cycle per assertion.
REQ-019 On load_use_hzd in RUN: pc_en=0, ifid_en=0 and idex_flush=1 in the same cycle, state stays RUN; back-to-back assertions SHALL each stall one cycle.
REQ-020 On md_req in RUN: md_start=1 for that cycle only, pc_en=ifid_en=idex_en=0, exmem_flush=1, and next state MD_WAIT.
REQ-021 In MD_WAIT: pc_en=ifid_en=idex_en=0 and exmem_flush=1; ex_branch_taken, load_use_hzd and md_req SHALL be ignored, and md_start SHALL stay 0.
REQ-022 In MD_WAIT with md_ready=1: all enables 1, exmem_flush=0 (the result is captured into EX/MEM), and next state RUN.
REQ-023 md_ready in RUN SHALL be ignored.
REQ-024 A wait counter SHALL clear on entry to MD_WAIT and increment each MD_WAIT cycle without md_ready.
REQ-025 When the wait counter reaches MD_TIMEOUT-1 with no md_ready: md_abort=1 for one cycle, md_err set, enables 1, exmem_flush=1 (the result is dropped), and next state RUN.
REQ-026 md_ready on the timeout cycle SHALL win: normal completion, no abort.
REQ-027 md_err SHALL stay set until reset.

Reset
REQ-028 With rst_n=0 at a clock edge: state RUN, wait counter 0, md_err 0, and both counters 0.
REQ-029 While rst_n=0, outputs SHALL be the RUN no-request values with md_start=md_abort=0, regardless of inputs.
REQ-030 Reset asserted in MD_WAIT SHALL abandon the operation without an md_abort pulse.

Configuration
REQ-031 Macro PIPE_PERF_CNT_EN SHALL select the performance-counter feature.
REQ-032 With PIPE_PERF_CNT_EN defined: stall_cnt +1 on every cycle pc_en=0; flush_cnt +1 on every cycle ifid_flush or idex_flush=1; both saturate at all-ones.
REQ-033 Without PIPE_PERF_CNT_EN: stall_cnt and flush_cnt tied to 0 and no counter flops generated.

Structure
REQ-034 Package pipe_ctrl_pkg SHALL hold the state enum (RUN, MD_WAIT) and the wait-counter width constant (8).
REQ-035 The saturating counter SHALL be sub-module pipe_perf_cnt with parameter CNT_W, instantiated twice, only under PIPE_PERF_CNT_EN.

Verification
REQ-036 Bench: load_use_hzd=1 for 2 cycles in RUN -> pc_en=0, ifid_en=0, idex_flush=1 for exactly 2 cycles; stall_cnt=2.
REQ-037 Bench: ex_branch_taken=1 and load_use_hzd=1 in the same cycle -> ifid_flush=idex_flush=1, pc_en=1; flush_cnt=1, stall_cnt=0.
REQ-038 Bench: md_req=1 held, md_ready raised on the 5th MD_WAIT cycle -> one md_start pulse, 5 frozen cycles, return to RUN, md_err=0.
REQ-039 Bench: MD_TIMEOUT=4, md_ready never asserted -> md_abort pulse on the 4th MD_WAIT cycle, md_err=1 sticky, state RUN.
REQ-040 Bench: rst_n=0 during MD_WAIT -> next cycle RUN, counters 0, no md_abort pulse.
REQ-041 Bench: CNT_W=4 with 20 stall cycles -> stall_cnt saturates at 15; build without PIPE_PERF_CNT_EN -> stall_cnt stays 0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl_pkg
// Purpose  : Shared types and constants for the pipeline stall/flush
//            controller: FSM state encoding and the mul/div wait-counter
//            width.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package pipe_ctrl_pkg;

  // Width of the MD_WAIT cycle counter; bounds MD_TIMEOUT to 255.
  localparam int WAIT_CNT_W = 8;

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } state_e;

endpackage
`default_nettype wire

// File: rtl/pipe_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl_if
// Purpose  : Hazard-request and pipeline-control bundle between the pipeline
//            and pipe_ctrl, including the mul/div unit handshake.
// Ports    : load_use_hzd, ex_branch_taken, md_req, md_ready  (requests)
//            md_start, md_abort                                (mul/div ctl)
//            pc_en, ifid_en, idex_en                           (enables)
//            ifid_flush, idex_flush, exmem_flush               (bubbles)
//            modport master : controller side
//            modport slave  : pipeline / mul-div side
// Revision : 1.0  initial release
// ============================================================================
interface pipe_ctrl_if;

  logic load_use_hzd;
  logic ex_branch_taken;
  logic md_req;
  logic md_ready;
  logic md_start;
  logic md_abort;
  logic pc_en;
  logic ifid_en;
  logic idex_en;
  logic ifid_flush;
  logic idex_flush;
  logic exmem_flush;

  modport master (
    input  load_use_hzd, ex_branch_taken, md_req, md_ready,
    output md_start, md_abort,
    output pc_en, ifid_en, idex_en,
    output ifid_flush, idex_flush, exmem_flush
  );

  modport slave (
    output load_use_hzd, ex_branch_taken, md_req, md_ready,
    input  md_start, md_abort,
    input  pc_en, ifid_en, idex_en,
    input  ifid_flush, idex_flush, exmem_flush
  );

endinterface
`default_nettype wire

// File: rtl/pipe_ctrl_perf_cnt.sv
`default_nettype none
// ============================================================================
// Module   : pipe_perf_cnt
// Purpose  : Saturating event counter; holds at all-ones once reached.
//            Only compiled when PIPE_PERF_CNT_EN is defined, so a build
//            without the performance counters carries no counter logic.
// Ports    : clk   - clock
//            rst_n - synchronous active-low reset
//            inc   - count enable for this cycle
//            cnt   - current count (CNT_W bits)
// Revision : 1.0  initial release
// ============================================================================
`ifdef PIPE_PERF_CNT_EN
module pipe_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign cnt = r_cnt;

endmodule
`endif
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl
// Purpose  : Pipeline stall/flush controller. Arbitrates mul/div issue,
//            taken-branch flush and load-use stall (in that priority), holds
//            the front of the pipe while a mul/div runs, and aborts the
//            mul/div after MD_TIMEOUT wait cycles. Outputs are Mealy.
// Ports    : clk       - clock
//            rst_n     - synchronous active-low reset
//            ctrl      - pipe_ctrl_if.master (requests, enables, flushes,
//                        mul/div start/abort)
//            md_err    - sticky mul/div timeout flag
//            stall_cnt - cycles with pc_en=0 (saturating)
//            flush_cnt - cycles with ifid_flush or idex_flush (saturating)
// Config   : PIPE_PERF_CNT_EN - enables stall_cnt/flush_cnt; otherwise both
//            are tied to zero.
// Revision : 1.0  initial release
// ============================================================================
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W      = 32,
  parameter int MD_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  pipe_ctrl_if.master      ctrl,
  output logic             md_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [WAIT_CNT_W-1:0] C_TIMEOUT_LAST = WAIT_CNT_W'(MD_TIMEOUT - 1);

  state_e                r_state;
  state_e                w_state_nxt;
  logic [WAIT_CNT_W-1:0] r_wait_cnt;
  logic                  r_md_err;
  logic                  w_timeout;

  logic w_pc_en;
  logic w_ifid_en;
  logic w_idex_en;
  logic w_ifid_flush;
  logic w_idex_flush;
  logic w_exmem_flush;
  logic w_md_start;
  logic w_md_abort;

  // Last permitted wait cycle reached without a result; md_ready on this
  // same cycle still completes normally.
  assign w_timeout = (r_wait_cnt == C_TIMEOUT_LAST) && !ctrl.md_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Held at zero in RUN so it is already clear on the first MD_WAIT cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wait_cnt <= '0;
    end else if (r_state != MD_WAIT) begin
      r_wait_cnt <= '0;
    end else if (!ctrl.md_ready) begin
      r_wait_cnt <= r_wait_cnt + WAIT_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_md_err <= 1'b0;
    end else if (w_md_abort) begin
      r_md_err <= 1'b1;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_pc_en       = 1'b1;
    w_ifid_en     = 1'b1;
    w_idex_en     = 1'b1;
    w_ifid_flush  = 1'b0;
    w_idex_flush  = 1'b0;
    w_exmem_flush = 1'b0;
    w_md_start    = 1'b0;
    w_md_abort    = 1'b0;

    // During reset everything stays at the free-running values.
    if (!rst_n) begin
      w_state_nxt = RUN;
    end else begin
      unique case (r_state)
        RUN: begin
          if (ctrl.md_req) begin
            w_md_start    = 1'b1;
            w_pc_en       = 1'b0;
            w_ifid_en     = 1'b0;
            w_idex_en     = 1'b0;
            w_exmem_flush = 1'b1;
            w_state_nxt   = MD_WAIT;
          end else if (ctrl.ex_branch_taken) begin
            w_ifid_flush = 1'b1;
            w_idex_flush = 1'b1;
          end else if (ctrl.load_use_hzd) begin
            w_pc_en      = 1'b0;
            w_ifid_en    = 1'b0;
            w_idex_flush = 1'b1;
          end
        end
        MD_WAIT: begin
          if (ctrl.md_ready) begin
            // Pipe advances and EX/MEM captures the mul/div result.
            w_state_nxt = RUN;
          end else if (w_timeout) begin
            // Pipe advances but the EX/MEM slot is bubbled: result dropped.
            w_md_abort    = 1'b1;
            w_exmem_flush = 1'b1;
            w_state_nxt   = RUN;
          end else begin
            w_pc_en       = 1'b0;
            w_ifid_en     = 1'b0;
            w_idex_en     = 1'b0;
            w_exmem_flush = 1'b1;
          end
        end
        default: w_state_nxt = RUN;
      endcase
    end
  end

  assign ctrl.pc_en       = w_pc_en;
  assign ctrl.ifid_en     = w_ifid_en;
  assign ctrl.idex_en     = w_idex_en;
  assign ctrl.ifid_flush  = w_ifid_flush;
  assign ctrl.idex_flush  = w_idex_flush;
  assign ctrl.exmem_flush = w_exmem_flush;
  assign ctrl.md_start    = w_md_start;
  assign ctrl.md_abort    = w_md_abort;
  assign md_err           = r_md_err;

`ifdef PIPE_PERF_CNT_EN
  pipe_perf_cnt #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (!w_pc_en),
    .cnt   (stall_cnt)
  );

  pipe_perf_cnt #(
    .CNT_W (CNT_W)
  ) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_ifid_flush || w_idex_flush),
    .cnt   (flush_cnt)
  );
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_ctrl
// Purpose  : Self-checking bench for pipe_ctrl. dut_a uses default
//            parameters; dut_b uses CNT_W=4, MD_TIMEOUT=4 for the timeout
//            and saturation cases. Counter expectations follow
//            PIPE_PERF_CNT_EN.
// Revision : 1.0  initial release
// ============================================================================
module tb_pipe_ctrl;

`ifdef PIPE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // {pc_en, ifid_en, idex_en, ifid_flush, idex_flush, exmem_flush, md_start, md_abort}
  localparam logic [7:0] DEF = 8'b111_000_00;

  logic clk;
  logic rst_a;
  logic rst_b;
  logic        err_a;
  logic        err_b;
  logic [31:0] stall_a;
  logic [31:0] flush_a;
  logic [3:0]  stall_b;
  logic [3:0]  flush_b;

  int n_checks;
  int n_fail;

  pipe_ctrl_if ia ();
  pipe_ctrl_if ib ();

  pipe_ctrl dut_a (
    .clk       (clk),
    .rst_n     (rst_a),
    .ctrl      (ia.master),
    .md_err    (err_a),
    .stall_cnt (stall_a),
    .flush_cnt (flush_a)
  );

  pipe_ctrl #(
    .CNT_W      (4),
    .MD_TIMEOUT (4)
  ) dut_b (
    .clk       (clk),
    .rst_n     (rst_b),
    .ctrl      (ib.master),
    .md_err    (err_b),
    .stall_cnt (stall_b),
    .flush_cnt (flush_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] out_a();
    return {ia.pc_en, ia.ifid_en, ia.idex_en, ia.ifid_flush,
            ia.idex_flush, ia.exmem_flush, ia.md_start, ia.md_abort};
  endfunction

  function automatic logic [7:0] out_b();
    return {ib.pc_en, ib.ifid_en, ib.idex_en, ib.ifid_flush,
            ib.idex_flush, ib.exmem_flush, ib.md_start, ib.md_abort};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge; outputs settle by +1.
  task automatic apply_a(input logic r, input logic l, input logic b,
                         input logic q, input logic m);
    @(negedge clk);
    rst_a = r; ia.load_use_hzd = l; ia.ex_branch_taken = b;
    ia.md_req = q; ia.md_ready = m;
    #1;
  endtask

  task automatic apply_b(input logic r, input logic l, input logic b,
                         input logic q, input logic m);
    @(negedge clk);
    rst_b = r; ib.load_use_hzd = l; ib.ex_branch_taken = b;
    ib.md_req = q; ib.md_ready = m;
    #1;
  endtask

  typedef struct {
    logic       rst_n;
    logic       luh;
    logic       br;
    logic       mdq;
    logic       mdr;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [12];

  initial begin
    int starts;
    int frozen;
    int aborts;

    n_checks = 0;
    n_fail   = 0;
    rst_a = 1'b0; ia.load_use_hzd = 1'b0; ia.ex_branch_taken = 1'b0;
    ia.md_req = 1'b0; ia.md_ready = 1'b0;
    rst_b = 1'b0; ib.load_use_hzd = 1'b0; ib.ex_branch_taken = 1'b0;
    ib.md_req = 1'b0; ib.md_ready = 1'b0;

    vecs[0]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, DEF};          // reset ignores requests
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, DEF};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, DEF};          // idle RUN
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'b111_110_00}; // branch flush
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'b001_010_00}; // load-use
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'b001_010_00}; // back-to-back
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'b111_110_00}; // branch beats load-use
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, DEF};          // md_ready in RUN ignored
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'b000_001_10}; // md_req wins, start
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'b000_001_00}; // MD_WAIT ignores all
    vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'b111_000_00}; // completion
    vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, DEF};          // back in RUN

    for (int i = 0; i < 12; i++) begin
      apply_a(vecs[i].rst_n, vecs[i].luh, vecs[i].br, vecs[i].mdq, vecs[i].mdr);
      check($sformatf("vec%0d_outputs", i), 64'(out_a()), 64'(vecs[i].exp));
      if (i == 2) begin
        check("reset_md_err", 64'(err_a), 64'(0));
        check("reset_stall_cnt", 64'(stall_a), 64'(0));
        check("reset_flush_cnt", 64'(flush_a), 64'(0));
      end
    end
    check("table_stall_cnt", 64'(stall_a), PERF ? 64'(4) : 64'(0));
    check("table_flush_cnt", 64'(flush_a), PERF ? 64'(4) : 64'(0));

    // Two-cycle load-use stall.
    apply_a(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    apply_a(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("lu2_c1", 64'(out_a()), 64'(8'b001_010_00));
    apply_a(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("lu2_c2", 64'(out_a()), 64'(8'b001_010_00));
    apply_a(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("lu2_after", 64'(out_a()), 64'(DEF));
    check("lu2_stall_cnt", 64'(stall_a), PERF ? 64'(2) : 64'(0));

    // Branch and load-use together: branch only.
    apply_a(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    apply_a(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("br_lu_outputs", 64'(out_a()), 64'(8'b111_110_00));
    apply_a(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("br_lu_flush_cnt", 64'(flush_a), PERF ? 64'(1) : 64'(0));
    check("br_lu_stall_cnt", 64'(stall_a), 64'(0));

    // md_req held, md_ready on the 5th MD_WAIT cycle.
    apply_a(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    starts = 0;
    frozen = 0;
    for (int c = 0; c < 5; c++) begin
      apply_a(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      starts += int'(ia.md_start);
      frozen += int'(!ia.pc_en);
    end
    apply_a(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    starts += int'(ia.md_start);
    frozen += int'(!ia.pc_en);
    check("md_done_outputs", 64'(out_a()), 64'(8'b111_000_00));
    apply_a(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("md_run_outputs", 64'(out_a()), 64'(DEF));
    check("md_start_pulses", 64'(starts), 64'(1));
    check("md_frozen_cycles", 64'(frozen), 64'(5));
    check("md_err_clear", 64'(err_a), 64'(0));
    check("md_stall_cnt", 64'(stall_a), PERF ? 64'(5) : 64'(0));

    // dut_b: md_ready on the timeout cycle wins.
    apply_b(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    apply_b(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("to_race_start", 64'(out_b()), 64'(8'b000_001_10));
    for (int c = 0; c < 3; c++) begin
      apply_b(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      check($sformatf("to_race_wait%0d", c + 1), 64'(out_b()), 64'(8'b000_001_00));
    end
    apply_b(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check("to_race_done", 64'(out_b()), 64'(8'b111_000_00));
    apply_b(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("to_race_run", 64'(out_b()), 64'(DEF));
    check("to_race_md_err", 64'(err_b), 64'(0));

    // dut_b: timeout abort on the 4th MD_WAIT cycle.
    apply_b(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int c = 0; c < 3; c++) begin
      apply_b(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      check($sformatf("to_wait%0d", c + 1), 64'(out_b()), 64'(8'b000_001_00));
    end
    apply_b(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("to_abort", 64'(out_b()), 64'(8'b111_001_01));
    apply_b(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("to_run", 64'(out_b()), 64'(DEF));
    check("to_md_err", 64'(err_b), 64'(1));
    for (int c = 0; c < 3; c++) apply_b(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("to_md_err_sticky", 64'(err_b), 64'(1));

    // dut_b: reset in MD_WAIT abandons the operation silently.
    apply_b(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    apply_b(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    apply_b(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    apply_b(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_wait_outputs", 64'(out_b()), 64'(DEF));
    apply_b(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_wait_run", 64'(out_b()), 64'(DEF));
    check("rst_wait_md_err", 64'(err_b), 64'(0));
    check("rst_wait_stall_cnt", 64'(stall_b), 64'(0));
    check("rst_wait_flush_cnt", 64'(flush_b), 64'(0));
    aborts = 0;
    for (int c = 0; c < 5; c++) begin
      apply_b(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      aborts += int'(ib.md_abort);
    end
    check("rst_wait_no_abort", 64'(aborts), 64'(0));

    // dut_b: 20 stall cycles saturate a 4-bit counter.
    apply_b(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 20; c++) apply_b(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    apply_b(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("sat_stall_cnt", 64'(stall_b), PERF ? 64'(15) : 64'(0));
    check("sat_flush_cnt", 64'(flush_b), PERF ? 64'(15) : 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
